// File: rtl/synth_param_loader_pkg.sv
// Shared constants for the synthesizer parameter loader: register IDs,
// rejection codes, field widths and the default frame header.
package synth_param_loader_pkg;

    localparam logic [7:0] DEFAULT_HEADER   = 8'hA5;

    localparam logic [7:0] ID_SIGNAL_TYPE   = 8'h01;
    localparam logic [7:0] ID_F_CARRIER     = 8'h02;
    localparam logic [7:0] ID_T_IMPULSE     = 8'h03;
    localparam logic [7:0] ID_VOBULATION    = 8'h04;
    localparam logic [7:0] ID_NUM_OF_IMP    = 8'h05;
    localparam logic [7:0] ID_DEVIATION     = 8'h06;
    localparam logic [7:0] ID_T_PERIOD_BASE = 8'h10;
    localparam logic [7:0] ID_START         = 8'h7E;
    localparam logic [7:0] ID_COMMIT        = 8'h7F;

    localparam int NUM_T_PERIOD = 10;

    localparam int SIG_W = 2;
    localparam int FC_W  = 32;
    localparam int TI_W  = 10;
    localparam int VOB_W = 1;
    localparam int NUM_W = 5;
    localparam int DEV_W = 22;
    localparam int TP_W  = 13;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_CHECKSUM   = 3'd1,
        ERR_TIMEOUT    = 3'd2,
        ERR_UNKNOWN_ID = 3'd3,
        ERR_RANGE      = 3'd4
    } err_code_e;

    // True when no bit of the payload lies above the target field width.
    function automatic logic fits_width(input logic [31:0] data, input logic [5:0] width);
        return (data >> width) == 32'd0;
    endfunction

endpackage

// File: rtl/synth_param_bank.sv
// Shadow/active parameter register file: per-ID write decode, range check,
// atomic commit copy and the direct start-generation level.
module synth_param_bank
    import synth_param_loader_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_exec,
    input  logic                i_csOk,
    input  logic [7:0]          i_id,
    input  logic [31:0]         i_data,
    output logic                o_pass,
    output err_code_e           o_errCode,
    output logic                o_start,
    output logic [SIG_W-1:0]    o_signalType,
    output logic [FC_W-1:0]     o_fCarrier,
    output logic [TI_W-1:0]     o_tImpulse,
    output logic                o_vobulation,
    output logic [NUM_W-1:0]    o_numOfImp,
    output logic [DEV_W-1:0]    o_deviation,
    output logic [TP_W-1:0]     o_tPeriod [NUM_T_PERIOD]
);

    logic [SIG_W-1:0] r_shSig, r_actSig;
    logic [FC_W-1:0]  r_shFc,  r_actFc;
    logic [TI_W-1:0]  r_shTi,  r_actTi;
    logic             r_shVob, r_actVob;
    logic [NUM_W-1:0] r_shNum, r_actNum;
    logic [DEV_W-1:0] r_shDev, r_actDev;
    logic [TP_W-1:0]  r_shTp  [NUM_T_PERIOD];
    logic [TP_W-1:0]  r_actTp [NUM_T_PERIOD];
    logic             r_start;

    logic [5:0] w_width;
    logic       w_known;

    // START and COMMIT carry no range-checked field, so they take the full 32-bit width.
    always_comb begin
        w_known = 1'b1;
        w_width = 6'd32;
        case (i_id)
            ID_SIGNAL_TYPE: w_width = 6'(SIG_W);
            ID_F_CARRIER:   w_width = 6'(FC_W);
            ID_T_IMPULSE:   w_width = 6'(TI_W);
            ID_VOBULATION:  w_width = 6'(VOB_W);
            ID_NUM_OF_IMP:  w_width = 6'(NUM_W);
            ID_DEVIATION:   w_width = 6'(DEV_W);
            ID_START, ID_COMMIT: w_width = 6'd32;
            default: begin
                w_known = (i_id >= ID_T_PERIOD_BASE) &&
                          (i_id <  ID_T_PERIOD_BASE + 8'(NUM_T_PERIOD));
                w_width = 6'(TP_W);
            end
        endcase
        if (!i_csOk)
            o_errCode = ERR_CHECKSUM;
        else if (!w_known)
            o_errCode = ERR_UNKNOWN_ID;
        else if (!fits_width(i_data, w_width))
            o_errCode = ERR_RANGE;
        else
            o_errCode = ERR_NONE;
        o_pass = (o_errCode == ERR_NONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shSig  <= '0;  r_actSig <= '0;
            r_shFc   <= '0;  r_actFc  <= '0;
            r_shTi   <= '0;  r_actTi  <= '0;
            r_shVob  <= 1'b0; r_actVob <= 1'b0;
            r_shNum  <= '0;  r_actNum <= '0;
            r_shDev  <= '0;  r_actDev <= '0;
            r_start  <= 1'b0;
            for (int k = 0; k < NUM_T_PERIOD; k++) begin
                r_shTp[k]  <= '0;
                r_actTp[k] <= '0;
            end
        end else if (i_exec && o_pass) begin
            case (i_id)
                ID_SIGNAL_TYPE: r_shSig <= i_data[SIG_W-1:0];
                ID_F_CARRIER:   r_shFc  <= i_data[FC_W-1:0];
                ID_T_IMPULSE:   r_shTi  <= i_data[TI_W-1:0];
                ID_VOBULATION:  r_shVob <= i_data[0];
                ID_NUM_OF_IMP:  r_shNum <= i_data[NUM_W-1:0];
                ID_DEVIATION:   r_shDev <= i_data[DEV_W-1:0];
                ID_START:       r_start <= i_data[0];
                ID_COMMIT: begin
                    r_actSig <= r_shSig;
                    r_actFc  <= r_shFc;
                    r_actTi  <= r_shTi;
                    r_actVob <= r_shVob;
                    r_actNum <= r_shNum;
                    r_actDev <= r_shDev;
                    for (int k = 0; k < NUM_T_PERIOD; k++)
                        r_actTp[k] <= r_shTp[k];
                end
                default: begin
                    for (int k = 0; k < NUM_T_PERIOD; k++)
                        if (i_id == ID_T_PERIOD_BASE + 8'(k))
                            r_shTp[k] <= i_data[TP_W-1:0];
                end
            endcase
        end
    end

    assign o_start      = r_start;
    assign o_signalType = r_actSig;
    assign o_fCarrier   = r_actFc;
    assign o_tImpulse   = r_actTi;
    assign o_vobulation = r_actVob;
    assign o_numOfImp   = r_actNum;
    assign o_deviation  = r_actDev;
    assign o_tPeriod    = r_actTp;

endmodule

// File: rtl/synth_param_loader.sv
// Byte-stream command decoder for digital_synthesizer_v1: frame FSM, byte
// assembly, checksum and inter-byte timeout around the parameter bank.
module synth_param_loader
    import synth_param_loader_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter logic [7:0] HEADER         = DEFAULT_HEADER
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic              SIGN_START_GEN,
    output logic [SIG_W-1:0]  SIGNAL_TYPE,
    output logic [FC_W-1:0]   F_CARRIER,
    output logic [TI_W-1:0]   T_IMPULSE,
    output logic              VOBULATION,
    output logic [TP_W-1:0]   T_PERIOD_1,
    output logic [TP_W-1:0]   T_PERIOD_2,
    output logic [TP_W-1:0]   T_PERIOD_3,
    output logic [TP_W-1:0]   T_PERIOD_4,
    output logic [TP_W-1:0]   T_PERIOD_5,
    output logic [TP_W-1:0]   T_PERIOD_6,
    output logic [TP_W-1:0]   T_PERIOD_7,
    output logic [TP_W-1:0]   T_PERIOD_8,
    output logic [TP_W-1:0]   T_PERIOD_9,
    output logic [TP_W-1:0]   T_PERIOD_10,
    output logic [NUM_W-1:0]  NUM_OF_IMP,
    output logic [DEV_W-1:0]  DEVIATION,
    output logic              FRAME_OK,
    output logic              FRAME_ERR,
    output logic [2:0]        ERR_CODE
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GET_ID = 3'd1;
    localparam logic [2:0] S_GET_D3 = 3'd2;
    localparam logic [2:0] S_GET_D2 = 3'd3;
    localparam logic [2:0] S_GET_D1 = 3'd4;
    localparam logic [2:0] S_GET_D0 = 3'd5;
    localparam logic [2:0] S_GET_CS = 3'd6;
    localparam logic [2:0] S_EXEC   = 3'd7;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]       r_state;
    logic             r_readyEn;
    logic [7:0]       r_id;
    logic [31:0]      r_data;
    logic [7:0]       r_csAcc;
    logic             r_csOk;
    logic [CNT_W-1:0] r_toCnt;
    logic             r_frameOk, r_frameErr;
    logic [2:0]       r_errCode;

    logic             w_accept, w_inFrame, w_timeout, w_exec, w_pass;
    err_code_e        w_bankErr;
    logic [TP_W-1:0]  w_tPeriod [NUM_T_PERIOD];

    // Ready is a flop so it stays low for the whole reset and rises on the first clock after release.
    assign RX_READY  = r_readyEn && (r_state != S_EXEC);
    assign w_accept  = RX_VALID && RX_READY;
    assign w_exec    = (r_state == S_EXEC);
    assign w_inFrame = (r_state != S_IDLE) && !w_exec;
    assign w_timeout = w_inFrame && !w_accept && (r_toCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            r_toCnt <= '0;
        else if (!w_inFrame || w_accept || w_timeout)
            r_toCnt <= '0;
        else
            r_toCnt <= r_toCnt + 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= S_IDLE;
            r_readyEn  <= 1'b0;
            r_id       <= '0;
            r_data     <= '0;
            r_csAcc    <= '0;
            r_csOk     <= 1'b0;
            r_frameOk  <= 1'b0;
            r_frameErr <= 1'b0;
            r_errCode  <= '0;
        end else begin
            r_readyEn  <= 1'b1;
            r_frameOk  <= 1'b0;
            r_frameErr <= 1'b0;
            case (r_state)
                S_IDLE:
                    if (w_accept && RX_DATA == HEADER)
                        r_state <= S_GET_ID;
                S_GET_ID:
                    if (w_accept) begin
                        r_id    <= RX_DATA;
                        r_csAcc <= RX_DATA;
                        r_state <= S_GET_D3;
                    end
                S_GET_D3, S_GET_D2, S_GET_D1, S_GET_D0:
                    if (w_accept) begin
                        r_data  <= {r_data[23:0], RX_DATA};
                        r_csAcc <= r_csAcc ^ RX_DATA;
                        r_state <= r_state + 3'd1;
                    end
                S_GET_CS:
                    if (w_accept) begin
                        r_csOk  <= (RX_DATA == r_csAcc);
                        r_state <= S_EXEC;
                    end
                default: begin
                    r_frameOk  <= w_pass;
                    r_frameErr <= !w_pass;
                    if (!w_pass)
                        r_errCode <= w_bankErr;
                    r_state <= S_IDLE;
                end
            endcase
            if (w_timeout) begin
                r_state    <= S_IDLE;
                r_frameErr <= 1'b1;
                r_errCode  <= ERR_TIMEOUT;
            end
        end
    end

    synth_param_bank u_bank (
        .i_clk        (CLK),
        .i_rst_n      (RESET),
        .i_exec       (w_exec),
        .i_csOk       (r_csOk),
        .i_id         (r_id),
        .i_data       (r_data),
        .o_pass       (w_pass),
        .o_errCode    (w_bankErr),
        .o_start      (SIGN_START_GEN),
        .o_signalType (SIGNAL_TYPE),
        .o_fCarrier   (F_CARRIER),
        .o_tImpulse   (T_IMPULSE),
        .o_vobulation (VOBULATION),
        .o_numOfImp   (NUM_OF_IMP),
        .o_deviation  (DEVIATION),
        .o_tPeriod    (w_tPeriod)
    );

    assign T_PERIOD_1  = w_tPeriod[0];
    assign T_PERIOD_2  = w_tPeriod[1];
    assign T_PERIOD_3  = w_tPeriod[2];
    assign T_PERIOD_4  = w_tPeriod[3];
    assign T_PERIOD_5  = w_tPeriod[4];
    assign T_PERIOD_6  = w_tPeriod[5];
    assign T_PERIOD_7  = w_tPeriod[6];
    assign T_PERIOD_8  = w_tPeriod[7];
    assign T_PERIOD_9  = w_tPeriod[8];
    assign T_PERIOD_10 = w_tPeriod[9];

    assign FRAME_OK  = r_frameOk;
    assign FRAME_ERR = r_frameErr;
    assign ERR_CODE  = r_errCode;

endmodule

// File: doc/synth_param_loader.md
Name: synth_param_loader

Overview:
- Byte-stream command decoder that drives the configuration ports of digital_synthesizer_v1 (SIGN_START_GEN, SIGNAL_TYPE, F_CARRIER, T_IMPULSE, VOBULATION, T_PERIOD_1..10, NUM_OF_IMP, DEVIATION).
- Frames arrive from the host link (UART/SPI byte receiver) and are written into shadow registers.
- Shadow registers are copied atomically to the active outputs on a COMMIT frame, so the synthesizer never sees a half-updated parameter set.

Parameters:
- TIMEOUT_CYCLES, 1000: maximum idle clocks between bytes inside a frame before the frame is aborted.
- HEADER, 8'hA5: frame start byte.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- RX_DATA  in  8  incoming byte.
- RX_VALID  in  1  RX_DATA valid.
- RX_READY  out  1  loader accepts a byte this cycle.
- SIGN_START_GEN  out  1  start-generation level to the synthesizer.
- SIGNAL_TYPE  out  2  active signal type.
- F_CARRIER  out  32  active carrier frequency, Hz.
- T_IMPULSE  out  10  active impulse length, us.
- VOBULATION  out  1  active vobulation enable.
- T_PERIOD_1..T_PERIOD_10  out  13 each  active periods, us.
- NUM_OF_IMP  out  5  active impulse count.
- DEVIATION  out  22  active deviation, Hz.
- FRAME_OK  out  1  one-cycle pulse: valid frame executed.
- FRAME_ERR  out  1  one-cycle pulse: frame rejected.
- ERR_CODE  out  3  reason for the last rejection; held until the next FRAME_ERR.

Behaviour:
- Reset (RESET=0, asynchronous): FSM goes to IDLE. All shadow and active registers, FRAME_OK, FRAME_ERR, ERR_CODE and the timeout counter clear to 0. RX_READY=0 while in reset, 1 after reset releases.
- Byte accepted on a rising edge where RX_VALID & RX_READY. RX_READY=1 in every state except EXEC.
- Frame format: HEADER, ID, D3, D2, D1, D0 (data MSB first), CS.
  - CS = ID ^ D3 ^ D2 ^ D1 ^ D0; the header is excluded.
- FSM states: IDLE -> GET_ID -> GET_D3 -> GET_D2 -> GET_D1 -> GET_D0 -> GET_CS -> EXEC -> IDLE.
  - IDLE: bytes other than HEADER are dropped silently, with no error.
  - A HEADER byte in any later state is treated as data; there is no resync.
- EXEC lasts exactly one cycle, the cycle after CS is accepted. Checks run in this order:
  1. Checksum mismatch -> ERR_CODE=1.
  2. Unknown ID -> ERR_CODE=3.
  3. Range violation -> ERR_CODE=4.
  - On a failure: FRAME_ERR pulses in EXEC and no register changes.
  - On a pass: the write happens and FRAME_OK pulses in EXEC.
- ID map:
  - 0x01 SIGNAL_TYPE (2b).
  - 0x02 F_CARRIER (32b).
  - 0x03 T_IMPULSE (10b).
  - 0x04 VOBULATION (1b).
  - 0x05 NUM_OF_IMP (5b).
  - 0x06 DEVIATION (22b).
  - 0x10..0x19 T_PERIOD_1..10 (13b).
  - 0x7E START: SIGN_START_GEN <= D0[0] directly; takes effect at the end of EXEC and bypasses the shadow.
  - 0x7F COMMIT: all active registers <= shadow on the EXEC edge; the data bytes are ignored.
- Range rule: the 32-bit data must fit the target width. Any nonzero bit above the field width -> error 4; data is never truncated.
- Latency: CS accepted at edge N -> shadow or active registers and FRAME_OK/FRAME_ERR valid after edge N+1. Active outputs change only on COMMIT or START.
- Timeout:
  - The counter runs in every state except IDLE and EXEC, and clears on each accepted byte.
  - When it reaches TIMEOUT_CYCLES: FRAME_ERR pulses, ERR_CODE=2, FSM goes to IDLE, and the partial frame is discarded.
  - If a byte is accepted in the same cycle the timeout would fire, the byte wins.
- COMMIT with no prior writes re-applies the current shadow; this is legal and gives FRAME_OK.
- Reset mid-frame discards the frame; all outputs return to their reset values.

Decomposition:
- Shared package holds:
  - Register ID constants.
  - ERR_CODE constants: 0 none, 1 checksum, 2 timeout, 3 unknown ID, 4 range.
  - Field widths: 2/32/10/1/5/22/13.
  - Default HEADER.
- One natural sub-module: synth_param_bank. It holds the shadow and active register file, the per-ID write decode, the range check and the commit copy. The top keeps the FSM, byte assembly, checksum and timeout.

Test Plan:
- F_CARRIER then commit:
  - Send A5 02 4D 7C 6D 00 5E -> FRAME_OK, F_CARRIER still 0.
  - Send A5 7F 00 00 00 00 7F -> F_CARRIER=1300000000 one cycle after CS.
- T_IMPULSE write: A5 03 00 00 00 0A 09 followed by commit -> T_IMPULSE=10, FRAME_OK twice, other outputs unchanged.
- Range error: A5 05 00 00 00 20 25 -> FRAME_ERR, ERR_CODE=4, NUM_OF_IMP shadow unchanged (verified via commit giving 0).
- Checksum error: A5 03 00 00 00 0A 00 -> FRAME_ERR, ERR_CODE=1. Unknown ID: A5 20 00 00 00 00 20 -> ERR_CODE=3.
- Timeout and resync:
  - Send A5 02 4D, then idle TIMEOUT_CYCLES clocks -> FRAME_ERR, ERR_CODE=2.
  - A following full START frame A5 7E 00 00 00 01 7F -> SIGN_START_GEN=1.
- Reset mid-frame: assert RESET after A5 06 00 -> all outputs 0, RX_READY=0 during reset. A valid frame after release executes normally.
